// File: rtl/reg_file_sb.sv
// reg_file_sb: 2**ADDR_BITS x DATA_BITS register file, 2 comb read ports, 1 write port, pending scoreboard, clear sweep.
// Latency: reads zero-latency, writes visible next cycle (RF_BYPASS_EN forwards same cycle).
// Backpressure: wr_ready low for the REG_COUNT-cycle sweep; writes and pend_set are dropped then.
module reg_file_sb #(
  parameter int                   DATA_BITS = 8,
  parameter int                   ADDR_BITS = 3,
  parameter logic [DATA_BITS-1:0] CLR_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_BITS-1:0]      rd_a_addr,
  output logic [DATA_BITS-1:0]      rd_a_data,
  output logic                      rd_a_pend,
  input  logic [ADDR_BITS-1:0]      rd_b_addr,
  output logic [DATA_BITS-1:0]      rd_b_data,
  output logic                      rd_b_pend,
  input  logic                      wr_en,
  input  logic [ADDR_BITS-1:0]      wr_addr,
  input  logic [DATA_BITS-1:0]      wr_data,
  output logic                      wr_ready,
  input  logic                      pend_set,
  input  logic [ADDR_BITS-1:0]      pend_addr,
  input  logic                      clr_req,
  output logic                      busy,
  output logic [(1<<ADDR_BITS)-1:0] pend_mask
);

  localparam int REG_COUNT = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(REG_COUNT - 1);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_BITS-1:0]   cnt, cnt_nxt;
  logic [DATA_BITS-1:0]   regs [REG_COUNT];
  logic [REG_COUNT-1:0]   pend_nxt;
  logic                   wr_acc;
  logic                   pend_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_ready  = 1'b1;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        wr_ready = 1'b0;
        busy     = 1'b1;
        cnt_nxt  = cnt + ADDR_BITS'(1);
        if (cnt == LAST_IDX) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_acc  = wr_en & wr_ready;
  assign pend_ok = pend_set & (state == IDLE);

  // Set wins over the write's clear when both target the same register.
  always_comb begin
    pend_nxt = pend_mask;
    if (state == SWEEP) begin
      pend_nxt[cnt] = 1'b0;
    end else begin
      if (wr_acc)  pend_nxt[wr_addr]   = 1'b0;
      if (pend_ok) pend_nxt[pend_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_mask <= '0;
    end else begin
      pend_mask <= pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= CLR_VALUE;
      end
    end else if (state == SWEEP) begin
      regs[cnt] <= CLR_VALUE;
    end else if (wr_acc) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_a_data = regs[rd_a_addr];
    rd_a_pend = pend_mask[rd_a_addr];
    rd_b_data = regs[rd_b_addr];
    rd_b_pend = pend_mask[rd_b_addr];
`ifdef RF_BYPASS_EN
    if (wr_acc && (rd_a_addr == wr_addr)) begin
      rd_a_data = wr_data;
      rd_a_pend = 1'b0;
    end
    if (wr_acc && (rd_b_addr == wr_addr)) begin
      rd_b_data = wr_data;
      rd_b_pend = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reads, writes, scoreboard, clear sweep, mid-sweep reset.
module tb_reg_file_sb;

  logic       clk;
  logic       reset_n;
  logic [2:0] rd_a_addr, rd_b_addr, wr_addr, pend_addr;
  logic [7:0] rd_a_data, rd_b_data, wr_data;
  logic       rd_a_pend, rd_b_pend;
  logic       wr_en, wr_ready, pend_set, clr_req, busy;
  logic [7:0] pend_mask;

  int vec  = 0;
  int miss = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file_sb dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_a_addr (rd_a_addr),
    .rd_a_data (rd_a_data),
    .rd_a_pend (rd_a_pend),
    .rd_b_addr (rd_b_addr),
    .rd_b_data (rd_b_data),
    .rd_b_pend (rd_b_pend),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .clr_req   (clr_req),
    .busy      (busy),
    .pend_mask (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 8; i++) begin
      rd_a_addr = 3'(i);
      rd_b_addr = 3'(7 - i);
      #1;
      chk({tag, "_a"}, {24'd0, rd_a_data}, {24'd0, exp});
      chk({tag, "_b"}, {24'd0, rd_b_data}, {24'd0, exp});
      chk({tag, "_ap"}, {31'd0, rd_a_pend}, 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pend_set = 1'b0; pend_addr = '0; clr_req = 1'b0;
    rd_a_addr = '0; rd_b_addr = '0;

    // 1: reset state
    #12;
    read_all("rst_read", 8'h00);
    chk("rst_pmask", {24'd0, pend_mask}, 32'h00);
    chk("rst_wrdy", {31'd0, wr_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // 2: write r3, same-cycle and next-cycle reads
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
    rd_a_addr = 3'd3; rd_b_addr = 3'd3;
    #1;
    chk("wr_same_a", {24'd0, rd_a_data}, BYP ? 32'hA5 : 32'h00);
    chk("wr_same_b", {24'd0, rd_b_data}, BYP ? 32'hA5 : 32'h00);
    step();
    wr_en = 1'b0; wr_addr = 'x; pend_addr = 'x;
    #1;
    chk("wr_next_a", {24'd0, rd_a_data}, 32'hA5);
    chk("wr_next_b", {24'd0, rd_b_data}, 32'hA5);
    step();
    chk("xaddr_pmask", {24'd0, pend_mask}, 32'h00);
    chk("xaddr_r3", {24'd0, rd_a_data}, 32'hA5);

    // 3: scoreboard
    pend_set = 1'b1; pend_addr = 3'd5; rd_a_addr = 3'd5;
    step();
    pend_set = 1'b0;
    #1;
    chk("pend_mask20", {24'd0, pend_mask}, 32'h20);
    chk("pend_rd1", {31'd0, rd_a_pend}, 32'd1);
    step();
    chk("pend_rd2", {31'd0, rd_a_pend}, 32'd1);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
    #1;
    chk("pend_wr_same", {31'd0, rd_a_pend}, BYP ? 32'd0 : 32'd1);
    step();
    wr_en = 1'b0;
    #1;
    chk("pend_cleared", {24'd0, pend_mask}, 32'h00);
    chk("pend_r5data", {24'd0, rd_a_data}, 32'h3C);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h77;
    pend_set = 1'b1; pend_addr = 3'd5;
    step();
    wr_en = 1'b0; pend_set = 1'b0;
    #1;
    chk("setwins_mask", {24'd0, pend_mask}, 32'h20);
    chk("setwins_data", {24'd0, rd_a_data}, 32'h77);
    chk("setwins_rdp", {31'd0, rd_a_pend}, 32'd1);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h44;
    pend_set = 1'b1; pend_addr = 3'd6;
    step();
    wr_en = 1'b0; pend_set = 1'b0; rd_b_addr = 3'd4;
    #1;
    chk("diff_mask", {24'd0, pend_mask}, 32'h60);
    chk("diff_data", {24'd0, rd_b_data}, 32'h44);

    // 4: load, pend r2, sweep
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'((i + 1) * 17);
      step();
    end
    wr_en = 1'b0;
    pend_set = 1'b1; pend_addr = 3'd2;
    step();
    pend_set = 1'b0;
    chk("load_pmask", {24'd0, pend_mask}, 32'h04);
    rd_a_addr = 3'd7;
    #1;
    chk("load_r7", {24'd0, rd_a_data}, 32'h88);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("sw_busy%0d", c), {31'd0, busy}, (c < 8) ? 32'd1 : 32'd0);
      chk($sformatf("sw_wrdy%0d", c), {31'd0, wr_ready}, (c < 8) ? 32'd0 : 32'd1);
      if (c == 2) begin
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'hFF;
      end
      if (c == 3) begin
        wr_addr = 3'd0; pend_set = 1'b1; pend_addr = 3'd1;
        rd_a_addr = 3'd0; rd_b_addr = 3'd5;
        #1;
        chk("sw_part_r0", {24'd0, rd_a_data}, 32'h00);
        chk("sw_part_r5", {24'd0, rd_b_data}, 32'h66);
      end
      if (c == 4) begin
        wr_en = 1'b0; pend_set = 1'b0;
      end
      step();
    end
    read_all("sw_after", 8'h00);
    chk("sw_pmask", {24'd0, pend_mask}, 32'h00);

    // 5: clr_req during sweep is ignored
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("rq_busy%0d", c), {31'd0, busy}, (c < 8) ? 32'd1 : 32'd0);
      clr_req = (c == 4);
      step();
    end
    clr_req = 1'b0;

    // 6: reset mid-sweep
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h99;
    step();
    wr_addr = 3'd6; wr_data = 8'h5A;
    step();
    wr_en = 1'b0; pend_set = 1'b1; pend_addr = 3'd7;
    step();
    pend_set = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step(); step(); step();
    rd_a_addr = 3'd4; rd_b_addr = 3'd6;
    #1;
    chk("pre_rst_r4", {24'd0, rd_a_data}, 32'h99);
    chk("pre_rst_r6", {24'd0, rd_b_data}, 32'h5A);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_wrdy", {31'd0, wr_ready}, 32'd1);
    chk("arst_r4", {24'd0, rd_a_data}, 32'h00);
    chk("arst_r6", {24'd0, rd_b_data}, 32'h00);
    chk("arst_pmask", {24'd0, pend_mask}, 32'h00);
    read_all("arst_read", 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h42;
    rd_a_addr = 3'd1;
    #1;
    chk("post_wrdy", {31'd0, wr_ready}, 32'd1);
    step();
    wr_en = 1'b0;
    #1;
    chk("post_r1", {24'd0, rd_a_data}, 32'h42);
    chk("post_busy", {31'd0, busy}, 32'd0);
    step();
    chk("post_busy2", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Architectural register file for the core: 2**ADDR_BITS registers of DATA_BITS each, two combinational read ports, one clocked write port.
- Feeds the operand-select 8:1 read muxes.
- Accepts the writeback value routed by the 1:8 destination demux.
- Holds a per-register pending scoreboard so decode can stall on in-flight loads.
- Provides a sequenced clear sweep for soft re-initialisation without asserting reset.

Parameters:
DATA_BITS, 8, register width
ADDR_BITS, 3, register index width; REG_COUNT = 2**ADDR_BITS (localparam, 8)
CLR_VALUE, 0, value written by the clear sweep and by reset

Ports:
clk  input  1  single clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
rd_a_addr  input  ADDR_BITS  read port A index
rd_a_data  output  DATA_BITS  read port A data, combinational
rd_a_pend  output  1  pending bit of rd_a_addr, combinational
rd_b_addr  input  ADDR_BITS  read port B index
rd_b_data  output  DATA_BITS  read port B data, combinational
rd_b_pend  output  1  pending bit of rd_b_addr, combinational
wr_en  input  1  write request
wr_addr  input  ADDR_BITS  write index
wr_data  input  DATA_BITS  write data
wr_ready  output  1  write accepted this cycle when wr_en & wr_ready
pend_set  input  1  mark pend_addr pending (load issued)
pend_addr  input  ADDR_BITS  register to mark pending
clr_req  input  1  start clear sweep (single-cycle pulse)
busy  output  1  clear sweep in progress
pend_mask  output  REG_COUNT  registered pending bits, bit i = register i

Behaviour:
- Reset (reset_n low, asynchronous):
  - all registers = CLR_VALUE; pend_mask = 0
  - FSM = IDLE; sweep counter = 0
  - busy = 0; wr_ready = 1
- Reads: zero latency. rd_x_data = reg[rd_x_addr]; rd_x_pend = pend_mask[rd_x_addr]. Both ports are independent and may use the same address.
- Write: accepted when wr_en & wr_ready. reg[wr_addr] <= wr_data and pend_mask[wr_addr] <= 0 at the next edge; visible on read ports the cycle after.
- pend_set (IDLE only): pend_mask[pend_addr] <= 1 at the next edge.
- Same-cycle accepted write and pend_set:
  - same address: pend bit ends at 1 (set has priority over clear); data is written.
  - different addresses: both take effect.
- FSM IDLE:
  - wr_ready = 1, busy = 0.
  - clr_req -> SWEEP, counter <= 0.
  - A write or pend_set in the same cycle as clr_req is still performed.
- FSM SWEEP:
  - busy = 1, wr_ready = 0; wr_en and pend_set are ignored (dropped, not queued).
  - Each cycle: reg[counter] <= CLR_VALUE, pend_mask[counter] <= 0, counter increments.
  - After counter == REG_COUNT-1 is written -> IDLE, counter <= 0.
  - Sweep occupies exactly REG_COUNT cycles; busy is high for REG_COUNT cycles starting the cycle after clr_req.
  - clr_req while in SWEEP is ignored; the sweep does not restart.
  - Reads during SWEEP return current contents: already-cleared registers read CLR_VALUE, the rest their old value.
- Counter is ADDR_BITS wide and wraps naturally from REG_COUNT-1 to 0; no other arithmetic.
- reset_n asserted mid-sweep: immediate return to reset state; the sweep does not resume.
- X on addresses while the matching enable is low must not corrupt state.

Optional Feature:
Macro RF_BYPASS_EN. When defined, a read port whose address equals wr_addr during an accepted write returns wr_data and rd_x_pend = 0 in that same cycle (write-through forwarding). Forwarding applies to both ports independently. When undefined, same-cycle reads return the old register value and old pending bit; the new value is visible one cycle later. Register update timing is identical in both builds.

Test Plan:
1. Reset then read all 8 indices on both ports -> data 0x00, rd_x_pend 0, pend_mask 0x00, wr_ready 1, busy 0.
2. Write 0xA5 to r3, next cycle read A=r3, B=r3 -> both 0xA5. Same-cycle read of r3 -> 0x00 (bypass off) / 0xA5 (RF_BYPASS_EN).
3. pend_set r5, then write 0x3C to r5 two cycles later:
   - rd_a_pend(r5) = 1 for the cycles between;
   - pend_mask = 0x20 then 0x00;
   - a simultaneous pend_set r5 + write r5 leaves pend_mask bit 5 = 1.
4. Load r0..r7 = 0x11..0x88, set pend r2, pulse clr_req:
   - busy high exactly 8 cycles; wr_ready low for the same 8 cycles;
   - a write 0xFF to r7 during the sweep is dropped;
   - afterwards all registers read 0x00 and pend_mask = 0x00.
5. Pulse clr_req, then pulse it again on sweep cycle 4 -> busy stays 8 cycles total, no restart.
6. Assert reset_n low on sweep cycle 3 -> busy 0 and all registers 0x00 immediately (asynchronously). After release, a write 0x42 to r1 is accepted on the first edge.
